// File: rtl/pll_ctrl_pkg.sv
// Shared types and encodings for the EHXPLLL dynamic phase-shift controller.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } state_e;

  // PHASESEL[1:0] encodings of the EHXPLLL outputs
  localparam logic [1:0] SEL_CLKOS  = 2'd0;
  localparam logic [1:0] SEL_CLKOS2 = 2'd1;
  localparam logic [1:0] SEL_CLKOS3 = 2'd2;
  localparam logic [1:0] SEL_CLKOP  = 2'd3;

  localparam logic DIR_ADVANCE = 1'b0;
  localparam logic DIR_DELAY   = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Lock supervisor: synchronises PLL LOCK and holds the downstream reset low
// until lock has been continuously high for LOCK_STABLE cycles.
module pll_lock_sync
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pll_locked,
  output logic locked_sync,
  output logic domain_rst_n
);

  localparam int unsigned CW = $clog2(LOCK_STABLE + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(LOCK_STABLE);

  logic          meta_d, meta_q;
  logic          sync_d, sync_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          rel_d, rel_q;

  // Counter saturates at LOCK_STABLE; any low synced sample restarts it.
  always_comb begin
    meta_d = pll_locked;
    sync_d = meta_q;
    cnt_d  = '0;
    if (sync_q) begin
      cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + CW'(1);
    end
    rel_d = (cnt_d == STABLE_MAX);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
      rel_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      rel_q  <= rel_d;
    end
  end

  assign locked_sync  = sync_q;
  assign domain_rst_n = rel_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequencer for the ECP5 EHXPLLL dynamic phase-shift port, with lock supervision.
// Requests arrive over valid/ready; each step is a timed active-low PHASESTEP pulse.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned STEP_W      = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg,
  output logic              locked_sync,
  output logic              domain_rst_n
);

  localparam int unsigned CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC)) + 1;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [STEP_W-1:0] rem_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        sel_q;
  logic              dir_q;
  logic              step_q;
  logic              in_step_seq;

  pll_lock_sync #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_sync (
    .clock        (clock),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .locked_sync  (locked_sync),
    .domain_rst_n (domain_rst_n)
  );

  assign in_step_seq = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_GAP);

  // Each state is entered with its outputs already set, so all outputs are registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT_LOCK;
      cyc_q   <= '0;
      rem_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= SEL_CLKOS;
      dir_q   <= DIR_DELAY;
      step_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (in_step_seq && !locked_sync) begin
        step_q  <= 1'b1;
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= ST_WAIT_LOCK;
      end else begin
        case (state_q)
          ST_WAIT_LOCK: begin
            if (domain_rst_n) begin
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          ST_IDLE: begin
            // A completed handshake wins over a same-cycle lock loss; the
            // sequence states then report the loss through err.
            if (req_valid && ready_q) begin
              ready_q <= 1'b0;
              sel_q   <= req_sel;
              dir_q   <= req_dir;
              rem_q   <= req_steps;
              if (req_steps == '0) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                busy_q  <= 1'b1;
                cyc_q   <= SETUP_LD;
                state_q <= ST_SETUP;
              end
            end else if (!locked_sync) begin
              ready_q <= 1'b0;
              state_q <= ST_WAIT_LOCK;
            end
          end
          ST_SETUP: begin
            if (cyc_q == '0) begin
              step_q  <= 1'b0;
              cyc_q   <= PULSE_LD;
              state_q <= ST_PULSE;
            end else begin
              cyc_q <= cyc_q - CNT_W'(1);
            end
          end
          ST_PULSE: begin
            if (cyc_q == '0) begin
              step_q  <= 1'b1;
              rem_q   <= rem_q - STEP_W'(1);
              cyc_q   <= GAP_LD;
              state_q <= ST_GAP;
            end else begin
              cyc_q <= cyc_q - CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (cyc_q == '0) begin
              if (rem_q != '0) begin
                step_q  <= 1'b0;
                cyc_q   <= PULSE_LD;
                state_q <= ST_PULSE;
              end else begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            end else begin
              cyc_q <= cyc_q - CNT_W'(1);
            end
          end
          ST_DONE: begin
            ready_q <= locked_sync;
            state_q <= locked_sync ? ST_IDLE : ST_WAIT_LOCK;
          end
          default: begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= 1'b1;
            state_q <= ST_WAIT_LOCK;
          end
        endcase
      end
    end
  end

  assign req_ready    = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = 1'b1;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: request vector table plus lock-drop,
// lock-glitch and mid-request reset sequences.
module tb_pll_phase_ctrl;

  localparam int S  = 2;
  localparam int P  = 3;
  localparam int G  = 4;
  localparam int L  = 16;
  localparam int SW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_dir = 1'b0;
  logic [1:0]    req_sel = 2'd0;
  logic [SW-1:0] req_steps = '0;
  logic          req_ready, busy, done, err, phasedir, phasestep, phaseloadreg;
  logic          locked_sync, domain_rst_n;
  logic [1:0]    phasesel;

  pll_phase_ctrl #(
    .SETUP_CYC   (S),
    .PULSE_CYC   (P),
    .GAP_CYC     (G),
    .LOCK_STABLE (L),
    .STEP_W      (SW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_dir      (req_dir),
    .req_steps    (req_steps),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .locked_sync  (locked_sync),
    .domain_rst_n (domain_rst_n)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    sel;
    logic          dir;
    logic [SW-1:0] steps;
    int            first_fall;
    int            done_lat;
    int            pulses;
  } vec_t;

  vec_t vecs[4];
  int   total = 0;
  int   bad = 0;
  int   n, ff, dl, np, perr, nd, nl, fl, fr, rr;
  logic prev, exp_low;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_req_ready"}, req_ready, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_err"}, err, 0);
    chk({p, "_phasesel"}, phasesel, 0);
    chk({p, "_phasedir"}, phasedir, 1);
    chk({p, "_phasestep"}, phasestep, 1);
    chk({p, "_phaseloadreg"}, phaseloadreg, 1);
    chk({p, "_locked_sync"}, locked_sync, 0);
    chk({p, "_domain_rst_n"}, domain_rst_n, 0);
  endtask

  // Called at a falling edge; returns at the falling edge of the first cycle after accept.
  task automatic start_req(input logic [1:0] s, input logic d, input logic [SW-1:0] k);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 200) begin
      @(negedge clock);
      w++;
    end
    chk("ready_before_req", req_ready, 1);
    req_sel   = s;
    req_dir   = d;
    req_steps = k;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          sel    dir   steps first done pulses
    vecs[0] = '{2'd1, 1'b1, 8'd3, 3, 24, 3};
    vecs[1] = '{2'd0, 1'b0, 8'd1, 3, 10, 1};
    vecs[2] = '{2'd3, 1'b1, 8'd0, 0, 1,  0};
    vecs[3] = '{2'd2, 1'b0, 8'd2, 3, 17, 2};

    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("nolock_ready", req_ready, 0);
    chk("nolock_domain_rst_n", domain_rst_n, 0);

    // Initial lock: locked_sync +2, domain_rst_n +18, req_ready +19
    pll_locked = 1'b1;
    fl = 0; fr = 0; rr = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (fl == 0 && locked_sync === 1'b1) fl = k;
      if (fr == 0 && domain_rst_n === 1'b1) fr = k;
      if (rr == 0 && req_ready === 1'b1) rr = k;
    end
    chk("lock_sync_lat", fl, 2);
    chk("lock_release_lat", fr, 18);
    chk("lock_ready_lat", rr, 19);

    for (int i = 0; i < 4; i++) begin
      start_req(vecs[i].sel, vecs[i].dir, vecs[i].steps);
      n = int'(vecs[i].steps);
      chk($sformatf("v%0d_busy_after_accept", i), busy, (n != 0));
      chk($sformatf("v%0d_phasesel", i), phasesel, vecs[i].sel);
      chk($sformatf("v%0d_phasedir", i), phasedir, vecs[i].dir);
      ff = 0; dl = 0; np = 0; perr = 0; prev = 1'b1;
      for (int k = 1; k <= 200; k++) begin
        if (k > 1) @(negedge clock);
        exp_low = (n != 0) && (k >= 1 + S) && (k < 1 + S + n * (P + G)) &&
                  (((k - 1 - S) % (P + G)) < P);
        if (phasestep !== !exp_low) perr++;
        if (phasestep === 1'b0 && ff == 0) ff = k;
        if (phasestep === 1'b0 && prev === 1'b1) np++;
        prev = phasestep;
        if (done === 1'b1) begin
          dl = k;
          break;
        end
      end
      chk($sformatf("v%0d_first_fall", i), ff, vecs[i].first_fall);
      chk($sformatf("v%0d_done_lat", i), dl, vecs[i].done_lat);
      chk($sformatf("v%0d_pulses", i), np, vecs[i].pulses);
      chk($sformatf("v%0d_step_pattern_errs", i), perr, 0);
      chk($sformatf("v%0d_busy_at_done", i), busy, 0);
      @(negedge clock);
      chk($sformatf("v%0d_ready_after_done", i), req_ready, 1);
      chk($sformatf("v%0d_done_one_cycle", i), done, 0);
      chk($sformatf("v%0d_phasesel_hold", i), phasesel, vecs[i].sel);
      chk($sformatf("v%0d_phasedir_hold", i), phasedir, vecs[i].dir);
    end

    // Lock lost so the synced drop lands in the 2nd pulse (cycle 10)
    start_req(2'd1, 1'b1, 8'd3);
    nd = 0; nl = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clock);
      if (k == 10) begin
        chk("drop_pulse2_low", phasestep, 0);
        chk("drop_sync_low", locked_sync, 0);
      end
      if (k == 11) begin
        chk("drop_phasestep_high", phasestep, 1);
        chk("drop_err", err, 1);
        chk("drop_busy", busy, 0);
        chk("drop_domain_rst_n", domain_rst_n, 0);
        chk("drop_ready", req_ready, 0);
      end
      if (k == 12) chk("drop_err_one_cycle", err, 0);
      if (done === 1'b1) nd++;
      if (k >= 11 && phasestep !== 1'b1) nl++;
      if (k == 8) pll_locked = 1'b0;
    end
    chk("drop_no_done", nd, 0);
    chk("drop_no_more_pulses", nl, 0);
    pll_locked = 1'b1;

    // One-cycle lock glitch while idle
    rr = 0;
    while (req_ready !== 1'b1 && rr < 100) begin
      @(negedge clock);
      rr++;
    end
    chk("glitch_pre_ready", req_ready, 1);
    pll_locked = 1'b0;
    fl = 0; fr = 0; rr = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clock);
      if (j == 1) pll_locked = 1'b1;
      if (j == 2) chk("glitch_sync_low", locked_sync, 0);
      if (j == 3) chk("glitch_ready_low", req_ready, 0);
      if (fl == 0 && domain_rst_n === 1'b0) fl = j;
      else if (fl != 0 && fr == 0 && domain_rst_n === 1'b1) fr = j;
      if (fr != 0 && rr == 0 && req_ready === 1'b1) rr = j;
    end
    chk("glitch_rst_fall", fl, 3);
    chk("glitch_rst_rise", fr, 19);
    chk("glitch_ready_rise", rr, 20);

    // Asynchronous reset in the first gap of a 3-step request
    start_req(2'd3, 1'b0, 8'd3);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_vals("arst");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    nl = 0; nd = 0; rr = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (phasestep !== 1'b1 || busy !== 1'b0) nl++;
      if (done === 1'b1) nd++;
      if (rr == 0 && req_ready === 1'b1) rr = k;
    end
    chk("arst_no_pulses", nl, 0);
    chk("arst_no_done", nd, 0);
    chk("arst_ready_relock", rr, 19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
